// File: rtl/chan_memory.sv
`default_nettype none
// ============================================================================
// Module   : chan_memory
// Purpose  : Single-array synchronous RAM of DEPTH words shared by N_PORTS
//            valid/ready request ports. A round-robin arbiter accepts at most
//            one access per clock. Each port owns a registered read response
//            that is held until the port drains it. Accepted accesses are
//            counted (saturating), and out-of-range addresses raise a sticky
//            flag.
// Revision : 1.0 - initial clocked implementation
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [N_PORTS]         per-port request valid
//   req_ready  out  [N_PORTS]         per-port request accepted (one-hot/zero)
//   req_we     in   [N_PORTS]         1 = write, 0 = read
//   req_addr   in   [N_PORTS*ADDR_W]  packed addresses, port i at i*ADDR_W
//   req_wdata  in   [N_PORTS*WIDTH]   packed write data
//   rsp_valid  out  [N_PORTS]         per-port read data valid
//   rsp_ready  in   [N_PORTS]         per-port read data consumed
//   rsp_rdata  out  [N_PORTS*WIDTH]   packed read data
//   wr_count   out  [CNT_W]           accepted writes, saturating
//   rd_count   out  [CNT_W]           accepted reads, saturating
//   addr_err   out  1                 sticky: an accepted address was >= DEPTH
// ============================================================================
module chan_memory #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int N_PORTS = 2,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_PORTS-1:0]          req_valid,
  output logic [N_PORTS-1:0]          req_ready,
  input  logic [N_PORTS-1:0]          req_we,
  input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [N_PORTS*WIDTH-1:0]    req_wdata,
  output logic [N_PORTS-1:0]          rsp_valid,
  input  logic [N_PORTS-1:0]          rsp_ready,
  output logic [N_PORTS*WIDTH-1:0]    rsp_rdata,
  output logic [CNT_W-1:0]            wr_count,
  output logic [CNT_W-1:0]            rd_count,
  output logic                        addr_err
);

  localparam int PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH may equal 2^ADDR_W, so the range compare needs one extra bit.
  localparam logic [ADDR_W:0]  C_DEPTH     = (ADDR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] C_LAST_PORT = PTR_W'(N_PORTS - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = {CNT_W{1'b1}};

  logic [WIDTH-1:0]   mem [DEPTH];

  logic [PTR_W-1:0]   r_rr_ptr;
  logic [N_PORTS-1:0] w_eligible;
  logic               w_gnt_any;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [WIDTH-1:0]   w_sel_wdata;
  logic               w_sel_we;
  logic               w_in_range;
  logic [WIDTH-1:0]   w_rd_word;

  // A port holding an undrained response is never granted, even for a write.
  // Gating with rst_n keeps req_ready low for the whole time reset is held.
  assign w_eligible = req_valid & ~rsp_valid & {N_PORTS{rst_n}};

  // Round-robin search starting at r_rr_ptr. The first pass covers ports at
  // or above the pointer; the second pass picks up the wrap-around ports
  // below it in ascending order, which is the same circular search order.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (!w_gnt_any && w_eligible[p] && (PTR_W'(p) >= r_rr_ptr)) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = PTR_W'(p);
      end
    end
    for (int p = 0; p < N_PORTS; p++) begin
      if (!w_gnt_any && w_eligible[p]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = PTR_W'(p);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_gnt_any) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  // req_ready is one-hot or zero, so an OR-free priority mux is sufficient.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (req_ready[p]) begin
        w_sel_addr  = req_addr[p*ADDR_W +: ADDR_W];
        w_sel_wdata = req_wdata[p*WIDTH +: WIDTH];
        w_sel_we    = req_we[p];
      end
    end
  end

  assign w_in_range = ({1'b0, w_sel_addr} < C_DEPTH);

  // Out-of-range reads return zero instead of an aliased array word.
  assign w_rd_word = w_in_range ? mem[w_sel_addr[MEM_AW-1:0]] : '0;

  // Array storage has no reset: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_gnt_any && w_sel_we && w_in_range) begin
      mem[w_sel_addr[MEM_AW-1:0]] <= w_sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      wr_count  <= '0;
      rd_count  <= '0;
      addr_err  <= 1'b0;
    end else begin
      // A granted port never has a pending response, so loading a new
      // response and draining an old one cannot collide on the same port.
      for (int p = 0; p < N_PORTS; p++) begin
        if (req_ready[p] && !w_sel_we) begin
          rsp_valid[p]                  <= 1'b1;
          rsp_rdata[p*WIDTH +: WIDTH]   <= w_rd_word;
        end else if (rsp_ready[p]) begin
          rsp_valid[p] <= 1'b0;
        end
      end

      if (w_gnt_any) begin
        r_rr_ptr <= (w_gnt_idx == C_LAST_PORT) ? '0 : w_gnt_idx + 1'b1;

        if (!w_in_range) begin
          addr_err <= 1'b1;
        end

        if (w_sel_we) begin
          if (wr_count != C_CNT_MAX) begin
            wr_count <= wr_count + CNT_W'(1);
          end
        end else begin
          if (rd_count != C_CNT_MAX) begin
            rd_count <= rd_count + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chan_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_chan_memory
// Purpose  : Self-checking bench for chan_memory. Directed phases follow the
//            load / backpressure / contention / write-read / out-of-range /
//            reset scenarios, then a randomized phase runs against a
//            cycle-level reference model built from the access rules.
//            ADDR_W is one bit wider than DEPTH needs so that out-of-range
//            addresses exist; CNT_W is small so counter saturation is reached.
// Revision : 1.0 - initial bench
// ============================================================================
module tb_chan_memory;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 256;
  localparam int ADDR_W  = 9;
  localparam int NP      = 2;
  localparam int CNT_W   = 9;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                   clk;
  logic                   rst_n;
  logic [NP-1:0]          req_valid;
  logic [NP-1:0]          req_ready;
  logic [NP-1:0]          req_we;
  logic [NP*ADDR_W-1:0]   req_addr;
  logic [NP*WIDTH-1:0]    req_wdata;
  logic [NP-1:0]          rsp_valid;
  logic [NP-1:0]          rsp_ready;
  logic [NP*WIDTH-1:0]    rsp_rdata;
  logic [CNT_W-1:0]       wr_count;
  logic [CNT_W-1:0]       rd_count;
  logic                   addr_err;

  chan_memory #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .N_PORTS (NP),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .wr_count  (wr_count),
    .rd_count  (rd_count),
    .addr_err  (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int  m_mem   [DEPTH];
  bit  m_known [DEPTH];
  bit  m_v     [NP];
  int  m_d     [NP];
  bit  m_dk    [NP];
  int  m_ptr, m_wr, m_rd;
  bit  m_err;
  int  cur_g;

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_v[p]  = 1'b0;
      m_d[p]  = 0;
      m_dk[p] = 1'b1;
    end
    m_ptr = 0;
    m_wr  = 0;
    m_rd  = 0;
    m_err = 1'b0;
  endtask

  function automatic int exp_grant();
    if (!rst_n) return -1;
    for (int k = 0; k < NP; k++) begin
      int p = (m_ptr + k) % NP;
      if (req_valid[p] && !m_v[p]) return p;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    cur_g = exp_grant();
    check("req_ready", req_ready, (cur_g < 0) ? 0 : (1 << cur_g));
    for (int p = 0; p < NP; p++) begin
      check($sformatf("rsp_valid%0d", p), rsp_valid[p], m_v[p]);
      if (m_v[p] && m_dk[p])
        check($sformatf("rsp_rdata%0d", p), rsp_rdata[p*WIDTH +: WIDTH], m_d[p]);
    end
    check("wr_count", wr_count, m_wr);
    check("rd_count", rd_count, m_rd);
    check("addr_err", addr_err, m_err);
  endtask

  task automatic model_edge();
    int a;
    int d;
    for (int p = 0; p < NP; p++)
      if (rsp_ready[p]) m_v[p] = 1'b0;
    if (cur_g >= 0) begin
      a = int'(req_addr[cur_g*ADDR_W +: ADDR_W]);
      d = int'(req_wdata[cur_g*WIDTH +: WIDTH]);
      if (req_we[cur_g]) begin
        if (a < DEPTH) begin
          m_mem[a]   = d;
          m_known[a] = 1'b1;
        end
        if (m_wr < CNT_MAX) m_wr++;
      end else begin
        m_v[cur_g] = 1'b1;
        if (a < DEPTH) begin
          m_d[cur_g]  = m_mem[a];
          m_dk[cur_g] = m_known[a];
        end else begin
          m_d[cur_g]  = 0;
          m_dk[cur_g] = 1'b1;
        end
        if (m_rd < CNT_MAX) m_rd++;
      end
      if (a >= DEPTH) m_err = 1'b1;
      m_ptr = (cur_g + 1) % NP;
    end
  endtask

  // Inputs are set after a falling edge; step checks, takes one rising edge,
  // advances the model and returns on the next falling edge.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input int p, input bit v, input bit we, input int addr, input int data);
    req_valid[p]                  = v;
    req_we[p]                     = we;
    req_addr[p*ADDR_W +: ADDR_W]  = ADDR_W'(addr);
    req_wdata[p*WIDTH +: WIDTH]   = WIDTH'(data);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_wr_count", wr_count, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst_n     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = '0;
    #2;
    do_reset();

    // Load: port 1 writes k <- k ^ A5 for every address, port 0 idle.
    rsp_ready = '1;
    for (int k = 0; k < 256; k++) begin
      drive(1, 1'b1, 1'b1, k, k ^ 8'hA5);
      step();
    end
    drive(1, 1'b0, 1'b0, 0, 0);
    check("load_wr_count", wr_count, 256);
    check("load_addr_err", addr_err, 0);

    // Readback of addr 200 with response held off for 5 cycles while the
    // port keeps requesting (must not be granted).
    rsp_ready = '0;
    drive(0, 1'b1, 1'b0, 200, 0);
    step();
    check("bp_valid", rsp_valid[0], 1);
    check("bp_rdata", rsp_rdata[7:0], 8'h6D);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold", rsp_rdata[7:0], 8'h6D);
    end
    drive(0, 1'b0, 1'b0, 0, 0);
    rsp_ready = 2'b01;
    step();
    check("bp_drain", rsp_valid[0], 0);

    // Contention: both ports write every cycle from a fresh reset.
    do_reset();
    rsp_ready = '1;
    for (int s = 0; s < 20; s++) begin
      drive(0, 1'b1, 1'b1, 16 + (s % 8), $urandom_range(0, 255));
      drive(1, 1'b1, 1'b1, 32 + (s % 8), $urandom_range(0, 255));
      #1;
      check("rr_grant", req_ready, (s % 2 == 0) ? 1 : 2);
      step();
    end
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
    check("cont_wr_count", wr_count, 20);

    // Write then read back on the next edge.
    drive(0, 1'b1, 1'b1, 3, 8'h42);
    step();
    drive(0, 1'b1, 1'b0, 3, 0);
    step();
    drive(0, 1'b0, 1'b0, 0, 0);
    check("wtr_rdata", rsp_rdata[7:0], 8'h42);
    step();

    // Out-of-range write and read; addr 300 must not alias onto addr 44.
    drive(0, 1'b1, 1'b1, 300, 8'hFF);
    step();
    check("oor_err", addr_err, 1);
    drive(0, 1'b1, 1'b0, 300, 0);
    step();
    drive(0, 1'b0, 1'b0, 0, 0);
    check("oor_rdata", rsp_rdata[7:0], 0);
    check("oor_wr_count", wr_count, 22);
    check("oor_rd_count", rd_count, 2);
    step();
    drive(0, 1'b1, 1'b0, 44, 0);
    step();
    drive(0, 1'b0, 1'b0, 0, 0);
    check("oor_no_alias", rsp_rdata[7:0], 8'h89);
    check("oor_sticky", addr_err, 1);
    step();

    // Reset mid-operation with a pending response and rd_count = 7.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      rsp_ready = '0;
      drive(0, 1'b1, 1'b0, i, 0);
      step();
      drive(0, 1'b0, 1'b0, 0, 0);
      if (i < 6) begin
        rsp_ready = '1;
        step();
      end
    end
    check("mid_valid", rsp_valid[0], 1);
    check("mid_rd_count", rd_count, 7);
    drive(0, 1'b1, 1'b0, 5, 0);
    #2;
    do_reset();
    rsp_ready = '0;
    drive(0, 1'b1, 1'b0, 200, 0);
    step();
    drive(0, 1'b0, 1'b0, 0, 0);
    check("preserved_rdata", rsp_rdata[7:0], 8'h6D);
    rsp_ready = '1;
    step();

    // Randomized traffic against the model (includes counter saturation).
    for (int c = 0; c < 2500; c++) begin
      for (int p = 0; p < NP; p++) begin
        drive(p, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 7) == 0) ? $urandom_range(256, 511) : $urandom_range(0, 255),
              $urandom_range(0, 255));
        rsp_ready[p] = $urandom_range(0, 1) == 1;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
